// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } conv_state_e;

  // Width needed to index n items. Never returns less than 1 bit.
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Full product width plus enough headroom to sum k*k products.
  function automatic int acc_w(input int dw, input int k);
    return 2 * dw + $clog2(k * k);
  endfunction

  // Number of valid-convolution positions along one axis.
  function automatic int out_n(input int n, input int k);
    return n - k + 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// acc_o is the accumulator plus the current product, i.e. the value the
// accumulator takes on the next enabled edge. The owner can register the
// final sum on the same edge as the last tap.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] a_x, b_x, prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d;

  assign a_x   = (2*DATA_W)'(a_i);
  assign b_x   = (2*DATA_W)'(b_i);
  assign prod  = a_x * b_x;
  assign acc_o = acc_q + ACC_W'(prod);

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_o;
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Sequential 2-D valid convolution: one tap per cycle through a single MAC,
// results streamed over valid/ready with optional ReLU.
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int IMG_N  = 4,
  parameter  int KER_K  = 3,
  localparam int OUT_N  = out_n(IMG_N, KER_K),
  localparam int ACC_W  = acc_w(DATA_W, KER_K),
  localparam int IA_W   = cw(IMG_N * IMG_N),
  localparam int RC_W   = cw(OUT_N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_relu,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [IA_W-1:0]          wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [RC_W-1:0]          out_row,
  output logic [RC_W-1:0]          out_col
);

  localparam int IS   = IMG_N * IMG_N;
  localparam int KS   = KER_K * KER_K;
  localparam int KA_W = cw(KS);
  localparam int TK_W = cw(KER_K);

  if (IMG_N < KER_K) begin : g_bad_params
    $error("conv_stream_engine: IMG_N must not be smaller than KER_K");
  end

  conv_state_e state_q, state_d;

  logic signed [DATA_W-1:0] img_q [IS];
  logic signed [DATA_W-1:0] ker_q [KS];

  logic [TK_W-1:0]         ti_q, tj_q;
  logic [RC_W-1:0]         r_q, c_q;
  logic                    relu_q;
  logic signed [ACC_W-1:0] out_data_q;
  logic signed [ACC_W-1:0] mac_sum;
  logic                    mac_en, mac_clr;
  logic                    last_tap, last_pos, start_ok, accept, wr_ok;
  logic [IA_W-1:0]         img_a;
  logic [KA_W-1:0]         ker_a;

  assign last_tap = (ti_q == TK_W'(KER_K - 1)) && (tj_q == TK_W'(KER_K - 1));
  assign last_pos = (r_q == RC_W'(OUT_N - 1)) && (c_q == RC_W'(OUT_N - 1));
  assign start_ok = (state_q == IDLE) && start;
  assign accept   = (state_q == OUT) && out_ready;
  assign wr_ok    = (state_q == IDLE) && wr_en;

  // Tap operand addresses: window origin (r,c) offset by tap (i,j).
  always_comb begin
    img_a = IA_W'((int'(r_q) + int'(ti_q)) * IMG_N + int'(c_q) + int'(tj_q));
    ker_a = KA_W'(int'(ti_q) * KER_K + int'(tj_q));
  end

  conv_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(mac_clr),
    .en_i (mac_en),
    .a_i  (img_q[img_a]),
    .b_i  (ker_q[ker_a]),
    .acc_o(mac_sum)
  );

  // Image/kernel register files; writes only land while idle and in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < IS; n++) img_q[n] <= '0;
      for (int n = 0; n < KS; n++) ker_q[n] <= '0;
    end else if (wr_ok) begin
      if (!wr_sel && (int'(wr_addr) < IS)) img_q[wr_addr] <= wr_data;
      if (wr_sel && (int'(wr_addr) < KS))  ker_q[KA_W'(wr_addr)] <= wr_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-state controls.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    out_valid = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = MAC;
          mac_clr = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_tap) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          mac_clr = 1'b1;
          state_d = last_pos ? DONE : MAC;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tap/position counters, ReLU latch and output capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ti_q       <= '0;
      tj_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      relu_q     <= 1'b0;
      out_data_q <= '0;
    end else if (start_ok) begin
      ti_q   <= '0;
      tj_q   <= '0;
      r_q    <= '0;
      c_q    <= '0;
      relu_q <= cfg_relu;
    end else if (state_q == MAC) begin
      if (tj_q == TK_W'(KER_K - 1)) begin
        tj_q <= '0;
        ti_q <= (ti_q == TK_W'(KER_K - 1)) ? '0 : ti_q + 1'b1;
      end else begin
        tj_q <= tj_q + 1'b1;
      end
      if (last_tap) out_data_q <= (relu_q && mac_sum[ACC_W-1]) ? '0 : mac_sum;
    end else if (accept && !last_pos) begin
      if (c_q == RC_W'(OUT_N - 1)) begin
        c_q <= '0;
        r_q <= r_q + 1'b1;
      end else begin
        c_q <= c_q + 1'b1;
      end
    end
  end

  assign out_data = out_data_q;
  assign out_row  = r_q;
  assign out_col  = c_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine: a plain-arithmetic convolution
// model queues expected results; monitors pop and compare on each handshake.
module tb_conv_stream_engine;

  localparam int N = 4, K = 3, ON = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_relu = 1'b0, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        busy, done, out_valid;
  logic [19:0] out_data;
  logic [0:0]  out_row, out_col;

  logic        b_wr_en = 1'b0, b_wr_sel = 1'b0, b_start = 1'b0, b_ready = 1'b1;
  logic [4:0]  b_wr_addr = '0;
  logic [7:0]  b_wr_data = '0;
  logic        b_busy, b_done, b_valid;
  logic [17:0] b_data;
  logic [1:0]  b_row, b_col;

  conv_stream_engine u_dut (
    .clk(clk), .rst(rst), .cfg_relu(cfg_relu), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
  );

  conv_stream_engine #(.DATA_W(8), .IMG_N(5), .KER_K(2)) u_dut5 (
    .clk(clk), .rst(rst), .cfg_relu(1'b0), .wr_en(b_wr_en), .wr_sel(b_wr_sel),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .start(b_start), .busy(b_busy),
    .done(b_done), .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
    .out_row(b_row), .out_col(b_col)
  );

  always #5 clk = ~clk;

  typedef struct { longint d; int r; int c; } exp_t;
  exp_t q[$];
  exp_t q2[$];
  int   img_m[N*N];
  int   ker_m[K*K];
  int   n_tests = 0, n_fail = 0;
  int   hold_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: direct sum over each window, ReLU clamps negatives.
  task automatic push_exp(input bit relu);
    for (int r = 0; r < ON; r++)
      for (int c = 0; c < ON; c++) begin
        longint s;
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += longint'(img_m[(r+i)*N + c + j]) * longint'(ker_m[i*K + j]);
        if (relu && s < 0) s = 0;
        q.push_back('{s, r, c});
      end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input bit sel, input int a, input int d, input bit commit);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(a); wr_data = 8'(d);
    tick();
    wr_en = 1'b0;
    if (commit) begin
      if (sel) begin if (a < K*K) ker_m[a] = d; end
      else if (a < N*N) img_m[a] = d;
    end
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic load_rand();
    for (int a = 0; a < N*N; a++) wr(1'b0, a, rnd8(), 1'b1);
    for (int a = 0; a < K*K; a++) wr(1'b1, a, rnd8(), 1'b1);
  endtask

  // One convolution run. hold: ready low for that many cycles at first valid;
  // bp: random ready; poke: wr_en+start while busy; sw: write with start;
  // abort_at: assert rst in that cycle.
  task automatic run(input bit relu, input int hold, input bit bp, input bit poke,
                     input bit sw, input int abort_at);
    int k, lat, dk, dcnt;
    cfg_relu = relu;
    start    = 1'b1;
    if (sw) begin
      int d;
      d = rnd8();
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 8'(d);
      img_m[5] = d;
    end
    push_exp(relu);
    k = 0; lat = 0; dk = 0; dcnt = 0;
    forever begin
      tick();
      k++;
      start = 1'b0; wr_en = 1'b0;
      if (out_valid && lat == 0) begin
        lat = k;
        chk("first_valid_latency", lat, 10);
        hold_cnt = hold;
      end
      if (done) dcnt++;
      if (abort_at > 0) begin
        if (k == abort_at) rst = 1'b1;
        if (k == abort_at + 1) begin
          chk("abort_busy", busy, 0);
          chk("abort_valid", out_valid, 0);
          rst = 1'b0;
          q.delete();
          foreach (img_m[a]) img_m[a] = 0;
          foreach (ker_m[a]) ker_m[a] = 0;
        end
        if (k == abort_at + 12) begin
          chk("abort_no_done", dcnt, 0);
          break;
        end
      end else begin
        if (dk != 0 && k == dk + 1) begin
          chk("done_one_cycle", done, 0);
          chk("idle_after_done", busy, 0);
          chk("all_results_out", q.size(), 0);
          break;
        end
        if (done && dk == 0) begin
          dk = k;
          if (hold == 0 && !bp) chk("done_cycle", dk, ON*ON*(K*K+1) + 1);
        end
      end
      if (poke && (k == 3 || k == 25 || k == 41)) begin
        wr_en = 1'b1; wr_sel = k[0]; wr_addr = '0; wr_data = 8'(rnd8()); start = 1'b1;
      end
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (k > 3000) begin
        chk("run_timeout", dk, 1);
        break;
      end
    end
    out_ready = 1'b1;
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  // Monitor for the default-parameter instance.
  initial begin
    bit     exp_done, held;
    longint hd;
    int     hr, hc;
    exp_t   e;
    exp_done = 1'b0; held = 1'b0; hd = 0; hr = 0; hc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done = 1'b0;
        held     = 1'b0;
      end else begin
        if (exp_done) begin
          chk("done_after_last", done, 1);
          exp_done = 1'b0;
        end else if (done) begin
          chk("spurious_done", done, 0);
        end
        if (held) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", $signed(out_data), hd);
          chk("hold_row", out_row, hr);
          chk("hold_col", out_col, hc);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("unexpected_out", q.size(), 1);
          else begin
            e = q.pop_front();
            chk("out_data", $signed(out_data), e.d);
            chk("out_row", out_row, e.r);
            chk("out_col", out_col, e.c);
            if (q.size() == 0) exp_done = 1'b1;
          end
        end
        held = out_valid && !out_ready;
        hd   = $signed(out_data);
        hr   = int'(out_row);
        hc   = int'(out_col);
      end
    end
  end

  // Monitor for the 5x5 / 2x2 instance.
  initial begin
    exp_t e2;
    forever begin
      @(negedge clk);
      if (!rst && b_valid && b_ready) begin
        if (q2.size() == 0) chk("b_unexpected_out", q2.size(), 1);
        else begin
          e2 = q2.pop_front();
          chk("b_out_data", $signed(b_data), e2.d);
          chk("b_out_row", b_row, e2.r);
          chk("b_out_col", b_col, e2.c);
        end
      end
    end
  end

  initial begin
    int k;
    foreach (img_m[a]) img_m[a] = 0;
    foreach (ker_m[a]) ker_m[a] = 0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    rst = 1'b0;
    tick();

    // Basic: image 1..16, kernel all ones -> 54, 63, 90, 99.
    for (int a = 0; a < N*N; a++) wr(1'b0, a, a + 1, 1'b1);
    for (int a = 0; a < K*K; a++) wr(1'b1, a, 1, 1'b1);
    run(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

    // Centre tap -1: negative results, then clamped by ReLU.
    for (int a = 0; a < K*K; a++) wr(1'b1, a, (a == 4) ? -1 : 0, 1'b1);
    run(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    run(1'b1, 0, 1'b0, 1'b0, 1'b0, 0);

    // Backpressure: ready low for 5 cycles once valid rises.
    load_rand();
    run(1'b0, 5, 1'b0, 1'b0, 1'b0, 0);

    // Extreme values: every element -128.
    for (int a = 0; a < N*N; a++) wr(1'b0, a, -128, 1'b1);
    for (int a = 0; a < K*K; a++) wr(1'b1, a, -128, 1'b1);
    run(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    run(1'b1, 0, 1'b0, 1'b0, 1'b0, 0);

    // Writes and start while busy must be ignored.
    load_rand();
    run(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
    run(1'b1, 0, 1'b0, 1'b0, 1'b0, 0);

    // Out-of-range kernel addresses are dropped.
    for (int a = K*K; a < 16; a++) wr(1'b1, a, rnd8(), 1'b1);
    run(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

    // Write in the start cycle is seen by the computation.
    run(1'b0, 0, 1'b0, 1'b0, 1'b1, 0);

    // Random data, random ReLU, random backpressure.
    repeat (6) begin
      load_rand();
      run(1'($urandom_range(0, 1)), 0, 1'b1, 1'b0, 1'b0, 0);
    end

    // Reset during the second output's MAC, then storage must read as zero.
    load_rand();
    run(1'b0, 0, 1'b0, 1'b0, 1'b0, 15);
    run(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    load_rand();
    run(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

    // 5x5 image, 2x2 kernel, all ones -> sixteen 4s.
    for (int a = 0; a < 25; a++) begin
      b_wr_en = 1'b1; b_wr_sel = 1'b0; b_wr_addr = 5'(a); b_wr_data = 8'd1;
      tick();
    end
    for (int a = 0; a < 4; a++) begin
      b_wr_en = 1'b1; b_wr_sel = 1'b1; b_wr_addr = 5'(a); b_wr_data = 8'd1;
      tick();
    end
    b_wr_en = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) q2.push_back('{4, r, c});
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    k = 1;
    while (!b_done && k < 500) begin
      tick();
      k++;
    end
    chk("b_done_seen", b_done, 1);
    chk("b_done_cycle", k, 16 * 5 + 1);
    chk("b_all_results_out", q2.size(), 0);
    tick();
    chk("b_idle_after_done", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
